// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - LEGv8 field packer writing encoded words into imem
// Optional range checking of immediates is compiled in with INSTR_ENC_RANGE_CHK_EN.
module instr_encoder #(
  parameter  int N     = 64,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    fmt,
  input  logic [4:0]    rd,
  input  logic [4:0]    rn,
  input  logic [4:0]    rm,
  input  logic [N-1:0]  imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          full,
  output logic          err,
  output logic [7:0]    err_count
);

`ifdef INSTR_ENC_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;

  localparam logic signed [N-1:0] D_MIN  = -256;
  localparam logic signed [N-1:0] D_MAX  = 255;
  localparam logic signed [N-1:0] CB_MIN = -262144;
  localparam logic signed [N-1:0] CB_MAX = 262143;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [31:0]     word_q;
  logic            full_q;
  logic            err_q;
  logic [7:0]      err_count_q;

  logic [31:0]     enc_word_d;
  logic            bad_fmt;
  logic            range_fail;
  logic            reject;
  logic signed [N-1:0] imm_s;

  assign imm_s = $signed(imm);

  // Pack the fields for the selected format and flag bundles that must not be written
  always_comb begin
    enc_word_d = '0;
    bad_fmt    = 1'b0;
    range_fail = 1'b0;
    case (fmt)
      3'd0: enc_word_d = {OP_ADD, rm, 6'b0, rn, rd};
      3'd1: enc_word_d = {OP_SUB, rm, 6'b0, rn, rd};
      3'd2: enc_word_d = {OP_AND, rm, 6'b0, rn, rd};
      3'd3: enc_word_d = {OP_ORR, rm, 6'b0, rn, rd};
      3'd4: begin
        enc_word_d = {OP_LDUR, imm[8:0], 2'b00, rn, rd};
        range_fail = (imm_s < D_MIN) || (imm_s > D_MAX);
      end
      3'd5: begin
        enc_word_d = {OP_STUR, imm[8:0], 2'b00, rn, rd};
        range_fail = (imm_s < D_MIN) || (imm_s > D_MAX);
      end
      3'd6: begin
        enc_word_d = {OP_CBZ, imm[18:0], rd};
        range_fail = (imm_s < CB_MIN) || (imm_s > CB_MAX);
      end
      default: bad_fmt = 1'b1;
    endcase
    reject = bad_fmt || (RANGE_CHK && range_fail);
  end

  assign in_ready   = (state_q == IDLE) && !full_q && !clear;
  // clear kills a pending strobe combinationally; reset does so through state_q
  assign imem_we    = (state_q == WRITE) && !clear;
  assign imem_addr  = wr_ptr_q;
  assign imem_wdata = word_q;
  assign full       = full_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

  // Accept/encode/write sequencing with write pointer, full flag and reject bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      word_q      <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else if (clear) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (reject) begin
              err_q <= 1'b1;
              if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            end else begin
              word_q  <= enc_word_d;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          state_q <= IDLE;
          // the last slot sets full and the pointer stays put rather than wrapping
          if (wr_ptr_q == LAST_ADDR) full_q   <= 1'b1;
          else                       wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder
module tb_instr_encoder;
  localparam int N     = 64;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

`ifdef INSTR_ENC_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [4:0]    rd, rn, rm;
  logic [N-1:0]  imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          full;
  logic          err;
  logic [7:0]    err_count;

  int n_cmp = 0;
  int n_bad = 0;

  int m_ptr  = 0;
  bit m_full = 1'b0;
  int m_cnt  = 0;
  logic [31:0] last_wdata;

  instr_encoder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .full(full), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input longint m);
    return ((v % m) + m) % m;
  endfunction

  // Expected word and reject decision from the instruction-set rules
  function automatic void model(input int f, input int a, input int b, input int c,
                                input longint im, output bit rej, output logic [31:0] w);
    longint t;
    longint op;
    t   = 0;
    rej = (f == 7);
    case (f)
      0, 1, 2, 3: begin
        op = (f == 0) ? 'h458 : (f == 1) ? 'h658 : (f == 2) ? 'h450 : 'h550;
        t  = op * 2097152 + c * 65536 + b * 32 + a;
      end
      4, 5: begin
        op = (f == 4) ? 'h7C2 : 'h7C0;
        t  = op * 2097152 + wrap(im, 512) * 4096 + b * 32 + a;
        if (RANGE_CHK && (im < -256 || im > 255)) rej = 1'b1;
      end
      6: begin
        t = 180 * 64'd16777216 + wrap(im, 524288) * 32 + a;
        if (RANGE_CHK && (im < -262144 || im > 262143)) rej = 1'b1;
      end
      default: t = 0;
    endcase
    w = t[31:0];
  endfunction

  function automatic longint rand_imm();
    longint edges [8] = '{-256, 255, 256, -257, -262144, 262143, 262144, -262145};
    case ($urandom_range(0, 3))
      0: return longint'($urandom_range(0, 600)) - 300;
      1: return longint'($urandom_range(0, 540000)) - 270000;
      2: return {$urandom, $urandom};
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  function automatic void model_clear();
    m_ptr  = 0;
    m_full = 1'b0;
    m_cnt  = 0;
  endfunction

  // Present one bundle at a negedge and check the whole handshake against the model
  task automatic send(input int f, input int a, input int b, input int c, input longint im);
    bit rej;
    logic [31:0] w;
    fmt = 3'(f); rd = 5'(a); rn = 5'(b); rm = 5'(c); imm = im;
    in_valid = 1'b1;
    #1;
    if (m_full) begin
      chk("ready_when_full", in_ready, 0);
      repeat (2) begin
        @(negedge clk);
        chk("we_when_full", imem_we, 0);
        chk("err_when_full", err, 0);
      end
      in_valid = 1'b0;
      return;
    end
    chk("ready", in_ready, 1);
    model(f, a, b, c, im, rej, w);
    @(negedge clk);
    in_valid = 1'b0;
    if (rej) begin
      if (m_cnt < 255) m_cnt++;
      chk("err_pulse", err, 1);
      chk("we_on_reject", imem_we, 0);
      chk("err_count", err_count, m_cnt);
      chk("addr_on_reject", imem_addr, m_ptr);
      @(negedge clk);
      chk("err_one_cycle", err, 0);
    end else begin
      chk("we", imem_we, 1);
      chk("addr", imem_addr, m_ptr);
      chk("wdata", imem_wdata, w);
      last_wdata = imem_wdata;
      if (m_ptr == DEPTH - 1) m_full = 1'b1;
      else m_ptr++;
      @(negedge clk);
      chk("we_drop", imem_we, 0);
      chk("full", full, m_full);
      chk("ready_again", in_ready, !m_full);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("ready_in_clear", in_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    #1;
    chk("clr_full", full, 0);
    chk("clr_err_count", err_count, 0);
    chk("clr_addr", imem_addr, 0);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    fmt = '0; rd = '0; rn = '0; rm = '0; imm = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);

    send(4, 1, 2, 0, 8);
    chk("spec_ldur", last_wdata, 32'hF8408041);
    send(6, 3, 7, 9, -2);
    chk("spec_cbz", last_wdata, 32'hB4FFFFC3);
    send(0, 9, 10, 11, 0);
    chk("spec_add", last_wdata, 32'h8B0B0149);
    send(5, 0, 0, 0, 256);
    if (!RANGE_CHK) chk("spec_stur", last_wdata, 32'hF8100000);
    else send(1, 4, 5, 6, 0);
    chk("full_after_depth", full, 1);
    send(2, 1, 1, 1, 0);
    do_clear();
    send(3, 2, 3, 4, 0);

    // clear during WRITE aborts the strobe
    fmt = 3'd0; rd = 5'd1; rn = 5'd2; rm = 5'd3; imm = '0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("clear_aborts_we", imem_we, 0);
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    #1;
    chk("after_abort_addr", imem_addr, 0);
    send(0, 1, 2, 3, 0);

    // reset during WRITE drops the strobe immediately
    send(7, 0, 0, 0, 0);
    send(7, 0, 0, 0, 0);
    fmt = 3'd1; rd = 5'd5; rn = 5'd6; rm = 5'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("we_before_reset", imem_we, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_drops_we", imem_we, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    #1;
    chk("post_rst_err_count", err_count, 0);
    chk("post_rst_addr", imem_addr, 0);
    chk("post_rst_ready", in_ready, 1);
    @(negedge clk);

    // saturating reject counter
    for (int i = 0; i < 260; i++) send(7, i % 32, 0, 0, 0);
    chk("err_count_saturated", err_count, 255);
    do_clear();

    for (int i = 0; i < 400; i++) begin
      if (m_full && $urandom_range(0, 2) == 0) do_clear();
      else send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), rand_imm());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
